// File: rtl/heartbeat_scheduler_if.sv
// Request channel between the heartbeat scheduler and the session message builder.
// The scheduler drives a valid/host/type request; the builder answers with ready.
interface heartbeat_scheduler_if #(
  parameter int HOST_AW = 2
);
  logic               msg_valid;
  logic               msg_ready;
  logic [HOST_AW-1:0] msg_host;
  logic [1:0]         msg_type;

  modport master (
    output msg_valid,
    output msg_host,
    output msg_type,
    input  msg_ready
  );

  modport slave (
    input  msg_valid,
    input  msg_host,
    input  msg_type,
    output msg_ready
  );
endinterface

// File: rtl/heartbeat_scheduler.sv
// heartbeat_scheduler: turns per-host heartbeat timeouts into queued Heartbeat /
// TestRequest requests for the message builder, tracks consecutive misses per
// host and flags link-down after MAX_MISS misses. Requests are served
// round-robin starting after the most recently completed host.
// Optional build macro HB_SCHED_STATS_EN adds saturating counters of completed
// Heartbeat and TestRequest handshakes (hb_sent_cnt_o / tr_sent_cnt_o).
module heartbeat_scheduler #(
  parameter int NUM_HOST = 4,
  parameter int HOST_AW  = 2,
  parameter int MAX_MISS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                timeout_i,
  input  logic [HOST_AW-1:0]  timeout_addr_i,
  input  logic                rx_valid_i,
  input  logic [HOST_AW-1:0]  rx_host_i,
  heartbeat_scheduler_if.master msg_if,
  output logic [NUM_HOST-1:0] link_down_o,
  output logic                busy_o
`ifdef HB_SCHED_STATS_EN
  ,
  output logic [15:0]         hb_sent_cnt_o,
  output logic [15:0]         tr_sent_cnt_o
`endif
);

  localparam int                MISS_W     = $clog2(MAX_MISS + 1);
  localparam logic [MISS_W-1:0] MISS_MAX   = MISS_W'(MAX_MISS);
  localparam logic [HOST_AW:0]  NUM_HOST_W = (HOST_AW + 1)'(NUM_HOST);
  localparam logic [1:0]        TYPE_HB    = 2'b00;
  localparam logic [1:0]        TYPE_TR    = 2'b01;
  localparam logic [0:0]        ST_IDLE    = 1'b0;
  localparam logic [0:0]        ST_SEND    = 1'b1;

  logic [0:0]                     state_q, state_d;
  logic [HOST_AW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [NUM_HOST-1:0]            pend_q, pend_d;
  logic [NUM_HOST-1:0]            link_down_q, link_down_d;
  logic [NUM_HOST-1:0][1:0]       req_type_q, req_type_d;
  logic [NUM_HOST-1:0][MISS_W-1:0] miss_q, miss_d;
  logic                           msg_valid_q, msg_valid_d;
  logic [HOST_AW-1:0]             msg_host_q, msg_host_d;
  logic [1:0]                     msg_type_q, msg_type_d;
  logic                           busy_q, busy_d;

  logic                           sel_found_s;
  logic                           sel_go_s;
  logic [HOST_AW-1:0]             sel_idx_s;
  logic [HOST_AW:0]               cand_s;
  logic                           to_valid_s;
  logic                           handshake_s;

  assign sel_go_s    = (state_q == ST_IDLE) && sel_found_s;
  assign handshake_s = (state_q == ST_SEND) && msg_if.msg_ready;
  assign to_valid_s  = timeout_i && ({1'b0, timeout_addr_i} < NUM_HOST_W);

  // Round-robin search: first pending host at or after rr_ptr, wrapping at NUM_HOST.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < NUM_HOST; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (HOST_AW + 1)'(i);
      if (cand_s >= NUM_HOST_W) begin
        cand_s = cand_s - NUM_HOST_W;
      end else begin
        cand_s = cand_s;
      end
      if (!sel_found_s && pend_q[cand_s[HOST_AW-1:0]]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s[HOST_AW-1:0];
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Per-host bookkeeping: selection clears pend, then rx clears misses, then timeout applies.
  always_comb begin
    pend_d      = pend_q;
    link_down_d = link_down_q;
    req_type_d  = req_type_q;
    miss_d      = miss_q;
    for (int h = 0; h < NUM_HOST; h++) begin
      if (sel_go_s && (sel_idx_s == HOST_AW'(h))) begin
        pend_d[h] = 1'b0;
      end else begin
        pend_d[h] = pend_q[h];
      end
      if (rx_valid_i && (rx_host_i == HOST_AW'(h))) begin
        miss_d[h]      = '0;
        link_down_d[h] = 1'b0;
      end else begin
        miss_d[h]      = miss_q[h];
      end
      if (to_valid_s && (timeout_addr_i == HOST_AW'(h)) && !link_down_d[h]) begin
        if (miss_d[h] == '0) begin
          req_type_d[h] = TYPE_HB;
        end else begin
          req_type_d[h] = TYPE_TR;
        end
        if (miss_d[h] != MISS_MAX) begin
          miss_d[h] = miss_d[h] + MISS_W'(1'b1);
        end else begin
          miss_d[h] = MISS_MAX;
        end
        // Reaching the miss limit declares the link down instead of sending.
        if (miss_d[h] == MISS_MAX) begin
          link_down_d[h] = 1'b1;
          pend_d[h]      = 1'b0;
        end else begin
          pend_d[h]      = 1'b1;
        end
      end else begin
        req_type_d[h] = req_type_q[h];
      end
    end
  end

  // Issue FSM: latch a selected request in IDLE, hold it in SEND until accepted.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    msg_valid_d = msg_valid_q;
    msg_host_d  = msg_host_q;
    msg_type_d  = msg_type_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_found_s) begin
          msg_host_d  = sel_idx_s;
          msg_type_d  = req_type_q[sel_idx_s];
          msg_valid_d = 1'b1;
          state_d     = ST_SEND;
        end else begin
          msg_valid_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (msg_if.msg_ready) begin
          msg_valid_d = 1'b0;
          state_d     = ST_IDLE;
          if ({1'b0, msg_host_q} == (NUM_HOST_W - (HOST_AW + 1)'(1))) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = msg_host_q + HOST_AW'(1);
          end
        end else begin
          msg_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        msg_valid_d = 1'b0;
      end
    endcase
    busy_d = (|pend_d) || (state_d == ST_SEND);
  end

  // State registers with synchronous reset; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      pend_q      <= '0;
      link_down_q <= '0;
      req_type_q  <= '0;
      miss_q      <= '0;
      msg_valid_q <= 1'b0;
      msg_host_q  <= '0;
      msg_type_q  <= TYPE_HB;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      link_down_q <= link_down_d;
      req_type_q  <= req_type_d;
      miss_q      <= miss_d;
      msg_valid_q <= msg_valid_d;
      msg_host_q  <= msg_host_d;
      msg_type_q  <= msg_type_d;
      busy_q      <= busy_d;
    end
  end

  assign msg_if.msg_valid = msg_valid_q;
  assign msg_if.msg_host  = msg_host_q;
  assign msg_if.msg_type  = msg_type_q;
  assign link_down_o      = link_down_q;
  assign busy_o           = busy_q;

`ifdef HB_SCHED_STATS_EN
  logic [15:0] hb_cnt_q;
  logic [15:0] tr_cnt_q;

  // Saturating counts of completed handshakes per message type.
  always_ff @(posedge clk) begin
    if (rst) begin
      hb_cnt_q <= 16'h0000;
      tr_cnt_q <= 16'h0000;
    end else if (handshake_s && (msg_type_q == TYPE_HB)) begin
      if (hb_cnt_q != 16'hFFFF) begin
        hb_cnt_q <= hb_cnt_q + 16'h0001;
      end
    end else if (handshake_s && (msg_type_q == TYPE_TR)) begin
      if (tr_cnt_q != 16'hFFFF) begin
        tr_cnt_q <= tr_cnt_q + 16'h0001;
      end
    end
  end

  assign hb_sent_cnt_o = hb_cnt_q;
  assign tr_sent_cnt_o = tr_cnt_q;
`endif

endmodule
